// File: rtl/addr_map_cfg.sv
// Shadow/active address-map store for the dynamic address decoder. Software edits the shadow copy
// through a request/grant port; a commit drains traffic, then copies shadow to active atomically.
module addr_map_cfg #(
    parameter  int unsigned NoRules      = 4,
    parameter  int unsigned AddrWidth    = 32,
    parameter  int unsigned IdxWidth     = 3,
    parameter  int unsigned DrainTimeout = 256,
    localparam int unsigned CfgAddrWidth = $clog2(NoRules) + 2,
    localparam int unsigned RuleWidth    = IdxWidth + 2 * AddrWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_req_i,
    input  logic                                cfg_we_i,
    input  logic [CfgAddrWidth-1:0]             cfg_addr_i,
    input  logic [AddrWidth-1:0]                cfg_wdata_i,
    output logic                                cfg_gnt_o,
    output logic                                cfg_rvalid_o,
    output logic [AddrWidth-1:0]                cfg_rdata_o,
    output logic                                cfg_err_o,
    input  logic                                commit_i,
    input  logic                                busy_i,
    output logic [NoRules-1:0][RuleWidth-1:0]   addr_map_o,
    output logic                                config_ongoing_o,
    output logic                                commit_done_o,
    output logic                                drain_timeout_o
);

    localparam int unsigned CntWidth = $clog2(DrainTimeout + 1);

    typedef struct packed {
        logic [IdxWidth-1:0]  idx;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
    } rule_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    // A disabled entry never matches a range and only the all-ones address in NAPOT mode.
    localparam rule_t RuleOff = '{
        idx:        {IdxWidth{1'b0}},
        start_addr: {AddrWidth{1'b1}},
        end_addr:   {AddrWidth{1'b1}}
    };

    state_e                    state_r;
    state_e                    state_s;
    logic [CntWidth-1:0]       drain_cnt_r;
    logic                      timeout_hit_s;
    logic                      done_r;
    logic                      drain_timeout_r;

    rule_t [NoRules-1:0]       shadow_r;
    logic  [NoRules-1:0]       shadow_en_r;
    rule_t [NoRules-1:0]       map_r;

    logic [CfgAddrWidth-1:0]   rule_sel_s;
    logic [1:0]                field_s;
    logic                      sel_valid_s;
    logic                      gnt_s;
    logic [AddrWidth-1:0]      rd_data_s;
    logic                      rvalid_r;
    logic [AddrWidth-1:0]      rdata_r;
    logic                      err_r;

    function automatic logic [AddrWidth-1:0] field_value(input rule_t rule, input logic en,
                                                         input logic [1:0] field);
        logic [AddrWidth-1:0] val;
        case (field)
            2'd0:    val = rule.start_addr;
            2'd1:    val = rule.end_addr;
            2'd2:    val = AddrWidth'(rule.idx);
            2'd3:    val = AddrWidth'(en);
            default: val = {AddrWidth{1'b0}};
        endcase
        return val;
    endfunction

    assign rule_sel_s    = cfg_addr_i >> 2;
    assign field_s       = cfg_addr_i[1:0];
    assign sel_valid_s   = (rule_sel_s < CfgAddrWidth'(NoRules));
    assign gnt_s         = cfg_req_i && (state_r == ST_IDLE) && !commit_i;
    assign timeout_hit_s = (drain_cnt_r == CntWidth'(DrainTimeout - 1));

    // Commit sequencer next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (commit_i) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!busy_i || timeout_hit_s) begin
                    state_s = ST_UPDATE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_UPDATE: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Commit sequencer state, drain counter and status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r         <= ST_IDLE;
            drain_cnt_r     <= {CntWidth{1'b0}};
            done_r          <= 1'b0;
            drain_timeout_r <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == ST_UPDATE);
            if (state_r == ST_DRAIN) begin
                drain_cnt_r <= drain_cnt_r + CntWidth'(1);
            end else begin
                drain_cnt_r <= {CntWidth{1'b0}};
            end
            if ((state_r == ST_IDLE) && commit_i) begin
                drain_timeout_r <= 1'b0;
            end else if ((state_r == ST_DRAIN) && busy_i && timeout_hit_s) begin
                drain_timeout_r <= 1'b1;
            end
        end
    end

    // Read mux over the shadow copy; out-of-range indices read as zero.
    always_comb begin
        rd_data_s = {AddrWidth{1'b0}};
        for (int r = 0; r < NoRules; r++) begin
            rd_data_s = (rule_sel_s == CfgAddrWidth'(r))
                      ? field_value(shadow_r[r], shadow_en_r[r], field_s) : rd_data_s;
        end
    end

    // Register port: shadow writes and the one-cycle-later response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_r    <= '0;
            shadow_en_r <= {NoRules{1'b0}};
            rvalid_r    <= 1'b0;
            rdata_r     <= {AddrWidth{1'b0}};
            err_r       <= 1'b0;
        end else begin
            rvalid_r <= gnt_s;
            err_r    <= gnt_s && !sel_valid_s;
            rdata_r  <= (gnt_s && !cfg_we_i) ? rd_data_s : {AddrWidth{1'b0}};
            if (gnt_s && cfg_we_i && sel_valid_s) begin
                for (int r = 0; r < NoRules; r++) begin
                    if (rule_sel_s == CfgAddrWidth'(r)) begin
                        case (field_s)
                            2'd0:    shadow_r[r].start_addr <= cfg_wdata_i;
                            2'd1:    shadow_r[r].end_addr   <= cfg_wdata_i;
                            2'd2:    shadow_r[r].idx        <= cfg_wdata_i[IdxWidth-1:0];
                            2'd3:    shadow_en_r[r]         <= cfg_wdata_i[0];
                            default: shadow_en_r[r]         <= shadow_en_r[r];
                        endcase
                    end
                end
            end
        end
    end

    // Active map holds the decoder-facing form, so disabled rules are folded in at update time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NoRules; r++) begin
                map_r[r] <= RuleOff;
            end
        end else if (state_r == ST_UPDATE) begin
            for (int r = 0; r < NoRules; r++) begin
                map_r[r] <= shadow_en_r[r] ? shadow_r[r] : RuleOff;
            end
        end
    end

    assign cfg_gnt_o        = gnt_s;
    assign cfg_rvalid_o     = rvalid_r;
    assign cfg_rdata_o      = rdata_r;
    assign cfg_err_o        = err_r;
    assign addr_map_o       = map_r;
    assign config_ongoing_o = (state_r != ST_IDLE);
    assign commit_done_o    = done_r;
    assign drain_timeout_o  = drain_timeout_r;

endmodule

// File: tb/tb_addr_map_cfg.sv
// Scoreboard bench for addr_map_cfg: register responses are checked by a monitor against a queue
// of expected values; commit timing and map contents are checked directly.
module tb_addr_map_cfg;

    localparam int NR = 5;
    localparam int AW = 32;
    localparam int IW = 3;
    localparam int DT = 8;
    localparam int CAW = $clog2(NR) + 2;
    localparam int RW = IW + 2 * AW;

    localparam logic [RW-1:0] DIS = {3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    typedef struct packed {
        logic [AW-1:0] rdata;
        logic          err;
    } resp_t;

    logic                   clk;
    logic                   rst;
    logic                   cfg_req;
    logic                   cfg_we;
    logic [CAW-1:0]         cfg_addr;
    logic [AW-1:0]          cfg_wdata;
    logic                   cfg_gnt;
    logic                   cfg_rvalid;
    logic [AW-1:0]          cfg_rdata;
    logic                   cfg_err;
    logic                   commit;
    logic                   busy;
    logic [NR-1:0][RW-1:0]  addr_map;
    logic                   ongoing;
    logic                   done;
    logic                   dto;

    resp_t exp_q[$];
    resp_t exp_r;
    int    checks = 0;
    int    errors = 0;
    int    ongoing_cnt = 0;
    int    done_cnt = 0;
    int    w;
    logic  found;

    addr_map_cfg #(
        .NoRules(NR), .AddrWidth(AW), .IdxWidth(IW), .DrainTimeout(DT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
        .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
        .commit_i(commit), .busy_i(busy), .addr_map_o(addr_map),
        .config_ongoing_o(ongoing), .commit_done_o(done), .drain_timeout_o(dto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one access, hold it until granted, and queue the expected response.
    task automatic cfg_access(input logic we, input int rule, input int field, input logic [AW-1:0] wdata,
                              input logic [AW-1:0] exp_rdata, input logic exp_err, output int waited);
        waited    = 0;
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_addr  = CAW'(rule * 4 + field);
        cfg_wdata = wdata;
        forever begin
            @(negedge clk);
            if (cfg_gnt) begin
                exp_q.push_back('{rdata: exp_rdata, err: exp_err});
                break;
            end
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL grant_timeout: got no grant for rule %0d field %0d", rule, field);
                break;
            end
        end
        @(posedge clk);
        #1;
        cfg_req = 1'b0;
    endtask

    // Response monitor: every rvalid pops one expectation.
    always @(negedge clk) begin
        if (!rst && cfg_rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got rdata %0h err %0b expected no response", cfg_rdata, cfg_err);
            end else begin
                exp_r = exp_q.pop_front();
                if (cfg_rdata !== exp_r.rdata || cfg_err !== exp_r.err) begin
                    errors++;
                    $display("FAIL resp: got rdata %0h err %0b expected rdata %0h err %0b",
                             cfg_rdata, cfg_err, exp_r.rdata, exp_r.err);
                end
            end
        end
    end

    // Commit activity counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (ongoing) ongoing_cnt++;
            if (done) done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        commit = 1'b0; busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int r = 0; r < NR; r++) check($sformatf("reset_map%0d", r), addr_map[r], DIS);
        check("reset_ongoing", ongoing, 1'b0);
        check("reset_timeout", dto, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rvalid", cfg_rvalid, 1'b0);
        @(posedge clk); #1;

        // Shadow writes and read-back
        cfg_access(1'b1, 1, 0, 32'h1000, 32'h0, 1'b0, w);
        cfg_access(1'b1, 1, 1, 32'h2000, 32'h0, 1'b0, w);
        cfg_access(1'b1, 1, 2, 32'h2, 32'h0, 1'b0, w);
        cfg_access(1'b1, 1, 3, 32'h1, 32'h0, 1'b0, w);
        cfg_access(1'b0, 1, 0, 32'h0, 32'h1000, 1'b0, w);
        cfg_access(1'b0, 1, 1, 32'h0, 32'h2000, 1'b0, w);
        cfg_access(1'b0, 1, 2, 32'h0, 32'h2, 1'b0, w);
        cfg_access(1'b0, 1, 3, 32'h0, 32'h1, 1'b0, w);
        cfg_access(1'b0, 0, 0, 32'h0, 32'h0, 1'b0, w);
        @(negedge clk);
        check("map1_before_commit", addr_map[1], DIS);
        @(posedge clk); #1;

        // Plain commit with no traffic in flight
        ongoing_cnt = 0; done_cnt = 0;
        commit = 1'b1;
        @(posedge clk); #1 commit = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                check("ongoing_at_done", ongoing, 1'b0);
                check("map1_at_done", addr_map[1], {3'd2, 32'h1000, 32'h2000});
                break;
            end
        end
        check("done_seen", found, 1'b1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk); #1;
        check("commit_ongoing_cycles", ongoing_cnt, 32'd2);
        check("commit_done_pulses", done_cnt, 32'd1);
        check("map0_still_off", addr_map[0], DIS);
        check("no_timeout", dto, 1'b0);

        // Drain timeout with a stalled request and an ignored second commit
        cfg_access(1'b1, 2, 0, 32'h3000, 32'h0, 1'b0, w);
        cfg_access(1'b1, 2, 1, 32'h3FFF, 32'h0, 1'b0, w);
        cfg_access(1'b1, 2, 2, 32'h5, 32'h0, 1'b0, w);
        cfg_access(1'b1, 2, 3, 32'h1, 32'h0, 1'b0, w);
        busy = 1'b1; ongoing_cnt = 0; done_cnt = 0;
        commit = 1'b1;
        fork
            begin
                @(posedge clk); #1 commit = 1'b0;
                repeat (2) @(posedge clk);
                #1 commit = 1'b1;
                @(posedge clk); #1 commit = 1'b0;
            end
        join_none
        cfg_access(1'b0, 2, 0, 32'h0, 32'h3000, 1'b0, w);
        check("stall_cycles_timeout", w, 32'd10);
        busy = 1'b0;
        @(negedge clk);
        check("timeout_flag", dto, 1'b1);
        check("timeout_ongoing_cycles", ongoing_cnt, 32'd9);
        check("timeout_done_pulses", done_cnt, 32'd1);
        check("map2_after_timeout", addr_map[2], {3'd5, 32'h3000, 32'h3FFF});
        @(posedge clk); #1;

        // Commit wins over a same-cycle request and clears the timeout flag
        ongoing_cnt = 0;
        commit = 1'b1;
        fork
            begin
                @(posedge clk); #1 commit = 1'b0;
            end
        join_none
        cfg_access(1'b0, 1, 2, 32'h0, 32'h2, 1'b0, w);
        check("stall_cycles_commit", w, 32'd3);
        @(negedge clk);
        check("timeout_cleared", dto, 1'b0);
        check("second_commit_ongoing", ongoing_cnt, 32'd2);
        @(posedge clk); #1;

        // Out-of-range rule indices
        cfg_access(1'b1, 5, 0, 32'hDEAD_BEEF, 32'h0, 1'b1, w);
        cfg_access(1'b1, 7, 3, 32'h1, 32'h0, 1'b1, w);
        cfg_access(1'b0, 5, 0, 32'h0, 32'h0, 1'b1, w);
        cfg_access(1'b0, 4, 0, 32'h0, 32'h0, 1'b0, w);
        cfg_access(1'b0, 1, 0, 32'h0, 32'h1000, 1'b0, w);
        cfg_access(1'b0, 1, 3, 32'h0, 32'h1, 1'b0, w);

        // Reset in the middle of a drain
        busy = 1'b1; done_cnt = 0;
        commit = 1'b1;
        @(posedge clk); #1 commit = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        busy = 1'b0;
        @(negedge clk);
        check("rst_mid_ongoing", ongoing, 1'b0);
        check("rst_mid_timeout", dto, 1'b0);
        for (int r = 0; r < NR; r++) check($sformatf("rst_mid_map%0d", r), addr_map[r], DIS);
        @(posedge clk); #1;
        repeat (5) @(posedge clk); #1;
        check("rst_mid_no_done", done_cnt, 32'd0);
        cfg_access(1'b0, 1, 0, 32'h0, 32'h0, 1'b0, w);
        cfg_access(1'b0, 2, 3, 32'h0, 32'h0, 1'b0, w);
        repeat (2) @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
